stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller sequencing the 4-digit BCD counter that feeds the 7-segment display path. Debounces three raw push-buttons and converts the 10 Hz square wave into single-cycle count enables. Issues clear pulses to the counter and selects live or frozen (lap) digits toward the segment driver. Sits between the 10 Hz generator, the BCD digit counter and the segment controller, all in the clk_100MHz domain.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 103 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and BCD limits for the stopwatch controller.
package stopwatch_pkg;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_max(input logic [15:0] digits);
        return digits == {4{BCD_MAX}};
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level counter and single-cycle press on debounced rise.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q, level_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencing of the BCD counter and display digit select.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STOP_AT_MAX     = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_10Hz,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [3:0] live_ones,
    input  logic [3:0] live_tens,
    input  logic [3:0] live_hundreds,
    input  logic [3:0] live_thousands,
    output logic       count_en,
    output logic       count_clr,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_hundreds,
    output logic [3:0] disp_thousands,
    output logic       running,
    output logic       lap_active
);
    logic        p_start, p_lap, p_clear;
    logic        start_p, lap_p, clr_p, tick;
    logic        t1_q, t2_q, t3_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] lap_q, lap_d, disp_q, disp_d, live;
    logic        en_q, en_d, clr_q, clr_d, run_q, run_d, lapact_q, lapact_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_start), .press(p_start));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_lap), .press(p_lap));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_clear), .press(p_clear));

    assign live    = {live_thousands, live_hundreds, live_tens, live_ones};
    assign tick    = t2_q & ~t3_q;
    assign clr_p   = p_clear;
    assign start_p = p_start & ~p_clear;
    assign lap_p   = p_lap & ~p_clear & ~p_start;

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        if (state_q == S_IDLE) begin
            state_d = start_p ? S_RUN : S_IDLE;
        end else if (state_q == S_PAUSE) begin
            state_d = clr_p ? S_IDLE : (start_p ? S_RUN : S_PAUSE);
            clr_d   = clr_p;
        end else if (start_p) begin
            state_d = S_PAUSE;
        end else if (lap_p) begin
            state_d = (state_q == S_RUN) ? S_LAP : S_RUN;
            lap_d   = (state_q == S_RUN) ? live : lap_q;
        end else if (tick) begin
            // Reaching 9999 pauses instead of incrementing when wrap is disabled.
            state_d = (STOP_AT_MAX != 0 && is_max(live)) ? S_PAUSE : state_q;
            en_d    = !(STOP_AT_MAX != 0 && is_max(live));
        end
        disp_d   = (state_d == S_LAP) ? lap_d : live;
        run_d    = state_d[0];
        lapact_d = state_d == S_LAP;
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            t1_q     <= 1'b0;
            t2_q     <= 1'b0;
            t3_q     <= 1'b0;
            state_q  <= S_IDLE;
            lap_q    <= '0;
            disp_q   <= '0;
            en_q     <= 1'b0;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
            lapact_q <= 1'b0;
        end else begin
            t1_q     <= clk_10Hz;
            t2_q     <= t1_q;
            t3_q     <= t2_q;
            state_q  <= state_d;
            lap_q    <= lap_d;
            disp_q   <= disp_d;
            en_q     <= en_d;
            clr_q    <= clr_d;
            run_q    <= run_d;
            lapact_q <= lapact_d;
        end
    end

    assign count_en   = en_q;
    assign count_clr  = clr_q;
    assign running    = run_q;
    assign lap_active = lapact_q;
    assign {disp_thousands, disp_hundreds, disp_tens, disp_ones} = disp_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with a queue-based scoreboard checked by a negedge monitor.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0, reset = 1'b0, clk_10Hz = 1'b0;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic [3:0] lo = 4'd0, lt = 4'd0, lh = 4'd0, lk = 4'd0;
    logic       en1, clr1, run1, lap1, en0, clr0, run0, lap0;
    logic [3:0] d1o, d1t, d1h, d1k, d0o, d0t, d0h, d0k;

    typedef struct {
        string       name;
        logic        run;
        logic        lap;
        logic [15:0] disp;
        int          en;
        int          clr;
        bit          chk0;
        logic        run0;
        int          en0;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   en_cnt = 0, clr_cnt = 0, en0_cnt = 0;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1)) dut (
        .clk_100MHz(clk), .reset(reset), .clk_10Hz(clk_10Hz),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .live_ones(lo), .live_tens(lt), .live_hundreds(lh), .live_thousands(lk),
        .count_en(en1), .count_clr(clr1),
        .disp_ones(d1o), .disp_tens(d1t), .disp_hundreds(d1h), .disp_thousands(d1k),
        .running(run1), .lap_active(lap1));

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_MAX(0)) dut0 (
        .clk_100MHz(clk), .reset(reset), .clk_10Hz(clk_10Hz),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .live_ones(lo), .live_tens(lt), .live_hundreds(lh), .live_thousands(lk),
        .count_en(en0), .count_clr(clr0),
        .disp_ones(d0o), .disp_tens(d0t), .disp_hundreds(d0h), .disp_thousands(d0k),
        .running(run0), .lap_active(lap0));

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: accumulates pulse counts and compares every queued expectation at the negedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        en_cnt  += int'(en1);
        clr_cnt += int'(clr1);
        en0_cnt += int'(en0);
        if (en_prev) chk("count_en_width", int'(en1), 0);
        en_prev = en1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".running"}, int'(run1), int'(e.run));
            chk({e.name, ".lap_active"}, int'(lap1), int'(e.lap));
            chk({e.name, ".disp"}, int'({d1k, d1h, d1t, d1o}), int'(e.disp));
            chk({e.name, ".count_en_pulses"}, en_cnt, e.en);
            chk({e.name, ".count_clr_pulses"}, clr_cnt, e.clr);
            if (e.chk0) begin
                chk({e.name, ".wrap_running"}, int'(run0), int'(e.run0));
                chk({e.name, ".wrap_count_en_pulses"}, en0_cnt, e.en0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string n, input logic r, input logic l, input logic [15:0] d,
                              input int en, input int clr, input bit c0, input logic r0, input int e0);
        exp_t e;
        e.name = n; e.run = r; e.lap = l; e.disp = d; e.en = en; e.clr = clr;
        e.chk0 = c0; e.run0 = r0; e.en0 = e0;
        q.push_back(e);
        cyc(1);
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        btn_start = s; btn_lap = l; btn_clear = c;
        cyc(12);
        btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        cyc(12);
    endtask

    task automatic tick_period(input int n);
        repeat (n) begin
            clk_10Hz = 1'b1;
            cyc(8);
            clk_10Hz = 1'b0;
            cyc(8);
        end
    endtask

    task automatic set_live(input logic [15:0] v);
        {lk, lh, lt, lo} = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(5);
        reset = 1'b1;
        cyc(2);
        expect_now("reset", 0, 0, 16'h0000, 0, 0, 1, 0, 0);
        tick_period(3);
        expect_now("idle_ticks", 0, 0, 16'h0000, 0, 0, 1, 0, 0);

        repeat (3) begin
            btn_start = 1'b1;
            cyc(2);
            btn_start = 1'b0;
            cyc(1);
        end
        press(1, 0, 0);
        expect_now("start_bouncy", 1, 0, 16'h0000, 0, 0, 1, 1, 0);
        tick_period(5);
        expect_now("five_ticks", 1, 0, 16'h0000, 5, 0, 1, 1, 5);

        set_live(16'h0421);
        cyc(3);
        expect_now("live_follow", 1, 0, 16'h0421, 5, 0, 1, 1, 5);
        press(0, 1, 0);
        expect_now("lap_enter", 1, 1, 16'h0421, 5, 0, 1, 1, 5);
        set_live(16'h0425);
        cyc(3);
        expect_now("lap_frozen", 1, 1, 16'h0421, 5, 0, 1, 1, 5);
        press(0, 1, 0);
        expect_now("lap_exit", 1, 0, 16'h0425, 5, 0, 1, 1, 5);

        press(0, 0, 1);
        expect_now("clear_in_run", 1, 0, 16'h0425, 5, 0, 1, 1, 5);
        press(1, 0, 0);
        expect_now("pause", 0, 0, 16'h0425, 5, 0, 1, 0, 5);
        press(1, 0, 1);
        expect_now("clear_beats_start", 0, 0, 16'h0425, 5, 1, 1, 0, 5);
        press(0, 0, 1);
        expect_now("clear_in_idle", 0, 0, 16'h0425, 5, 1, 1, 0, 5);
        press(1, 0, 0);
        expect_now("restart", 1, 0, 16'h0425, 5, 1, 1, 1, 5);

        set_live(16'h9999);
        tick_period(1);
        expect_now("max_tick", 0, 0, 16'h9999, 5, 1, 1, 1, 6);

        set_live(16'h0037);
        press(1, 0, 0);
        expect_now("resume", 1, 0, 16'h0037, 5, 1, 0, 0, 0);
        press(0, 1, 0);
        expect_now("lap_again", 1, 1, 16'h0037, 5, 1, 0, 0, 0);
        clk_10Hz = 1'b1;
        cyc(1);
        #2 reset = 1'b0;
        expect_now("reset_in_lap", 0, 0, 16'h0000, 5, 1, 1, 0, 6);
        cyc(2);
        reset = 1'b1;
        clk_10Hz = 1'b0;
        cyc(10);
        press(1, 0, 0);
        expect_now("start_after_reset", 1, 0, 16'h0037, 5, 1, 1, 1, 6);
        tick_period(1);
        expect_now("tick_after_reset", 1, 0, 16'h0037, 6, 1, 1, 1, 7);

        for (int i = 0; i < 10 && q.size() > 0; i++) cyc(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
